fifo_rd_drain: RTL

Read-side consumer of the asynchronous FIFO, in the `rclk` domain. It pops words from the FIFO whenever it has buffer space, and absorbs the one-cycle read latency in a 2-entry skid buffer. It presents the data on a valid/ready stream to the downstream datapath and marks burst boundaries with `out_last`.

---
 rtl/definitions.sv | 19 +
 rtl/rd_skid_buf.sv | 74 +++++++
 rtl/fifo_rd_drain.sv | 114 +++++++++++
 3 files changed

// File: rtl/definitions.sv
// ============================================================================
// Module      : definitions (package)
// Description : Shared async-FIFO parameters and the read-drain FSM state type.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package definitions;
    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rd_state_t;
endpackage

`default_nettype wire

// File: rtl/rd_skid_buf.sv
// ============================================================================
// Module      : rd_skid_buf
// Description : 2-entry circular skid buffer with occupancy; optional parity
//               bit per entry when RD_PARITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rd_skid_buf
    import definitions::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr,
    input  logic [DATASIZE-1:0] i_wdata,
    input  logic                i_rd,
    output logic [DATASIZE-1:0] o_rdata,
`ifdef RD_PARITY_EN
    output logic                o_par,
`endif
    output logic [1:0]          o_occ
);

`ifdef RD_PARITY_EN
    localparam int ENTRY_W = DATASIZE + 1;
`else
    localparam int ENTRY_W = DATASIZE;
`endif

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_occ;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

`ifdef RD_PARITY_EN
    assign w_entry = {^i_wdata, i_wdata};
    assign o_par   = w_head[DATASIZE];
`else
    assign w_entry = i_wdata;
`endif

    assign w_head  = r_mem[r_rptr];
    assign o_rdata = w_head[DATASIZE-1:0];
    assign o_occ   = r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_wr) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= ~r_wptr;
            end
            if (i_rd) begin
                r_rptr <= ~r_rptr;
            end
            // Simultaneous write and pop leaves occupancy unchanged
            case ({i_wr, i_rd})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side FIFO consumer: credit-based pops into a 2-entry skid
//               buffer, valid/ready output with burst-last marking.
//               Optional out_par port with macro RD_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_drain
    import definitions::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                remty,
    input  logic                rack,
    input  logic [DATASIZE-1:0] rdata,
    output logic                ren,
    output logic                ridle,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_last
`ifdef RD_PARITY_EN
    ,
    output logic                out_par
`endif
);

    localparam logic [7:0] C_LAST = 8'(BURST_LEN - 1);

    rd_state_t   r_state;
    rd_state_t   w_state_nxt;
    logic        r_inflight;
    logic [7:0]  r_bcnt;
    logic [1:0]  w_occ;
    logic        w_pop_out;
    logic        w_wr;
    logic        w_credit_ok;
    logic        w_hold;

    rd_skid_buf u_buf (
        .clk     (rclk),
        .rst     (rrst),
        .i_wr    (w_wr),
        .i_wdata (rdata),
        .i_rd    (w_pop_out),
        .o_rdata (out_data),
`ifdef RD_PARITY_EN
        .o_par   (out_par),
`endif
        .o_occ   (w_occ)
    );

    assign out_valid = (w_occ != 2'd0);
    assign w_pop_out = out_valid && out_ready;
    assign out_last  = out_valid && (r_bcnt == C_LAST);

    // A rack only counts when a pop was issued the cycle before
    assign w_wr = rack && r_inflight;

    // Credit: entries held plus the one in flight, less the one leaving now
    assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_out});
    assign ren = !rrst && !remty && w_credit_ok && !w_hold;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_inflight <= 1'b0;
            r_bcnt     <= 8'd0;
        end else begin
            r_inflight <= ren;
            if (w_pop_out) begin
                r_bcnt <= out_last ? 8'd0 : r_bcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ren) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_occ == 2'd2 && !out_ready)
                    w_state_nxt = HOLD;
                else if (w_occ == 2'd0 && !r_inflight && remty)
                    w_state_nxt = IDLE;
            end
            HOLD: begin
                if (out_ready) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ridle  = (r_state == IDLE);
        w_hold = (r_state == HOLD);
    end

endmodule

`default_nettype wire
